// File: rtl/alu_logger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_logger_pkg
// Description : ALU opcode encoding and shared result function for the logger.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_logger_pkg;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        OR  = 2'b11
    } alu_op_e;

    // Widest operand alu_f supports; callers zero-extend in and truncate out,
    // which keeps ADD/SUB modulo 2^width for any narrower width.
    localparam int ALU_MAX_W = 64;

    function automatic logic [ALU_MAX_W-1:0] alu_f(
        input alu_op_e              op,
        input logic [ALU_MAX_W-1:0] a,
        input logic [ALU_MAX_W-1:0] b
    );
        logic [ALU_MAX_W-1:0] res;
        case (op)
            ADD:     res = a + b;
            SUB:     res = a - b;
            AND:     res = a & b;
            default: res = a | b;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_logger_alu.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_logger_alu
// Description : Combinational ALU (ADD/SUB/AND/OR) feeding the result logger.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_logger_alu
    import alu_logger_pkg::*;
#(
    parameter int width_p = 8
) (
    input  logic [1:0]         sel_i,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic [width_p-1:0] res_o
);

    alu_op_e w_op;

    assign w_op  = alu_op_e'(sel_i);
    assign res_o = width_p'(alu_f(w_op, ALU_MAX_W'(a_i), ALU_MAX_W'(b_i)));

endmodule
`default_nettype wire

// File: rtl/alu_result_logger.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_logger
// Description : Logs ALU results to a 1rw SRAM with arbitrated readback port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_logger
    import alu_logger_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 512,
    parameter int wrap_p  = 0,
    localparam int c_addr_w = $clog2(els_p),
    localparam int c_cnt_w  = $clog2(els_p + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                op_v_i,
    output logic                op_ready_o,
    input  logic [1:0]          sel_i,
    input  logic [width_p-1:0]  a_i,
    input  logic [width_p-1:0]  b_i,
    input  logic                rd_v_i,
    input  logic [c_addr_w-1:0] rd_addr_i,
    output logic                rd_v_o,
    output logic [width_p-1:0]  rd_data_o,
    output logic [c_cnt_w-1:0]  count_o,
    output logic                full_o,
    output logic                sram_ce_o,
    output logic                sram_we_o,
    output logic [c_addr_w-1:0] sram_addr_o,
    output logic [width_p-1:0]  sram_wd_o,
    output logic [width_p-1:0]  sram_w_mask_o,
    input  logic [width_p-1:0]  sram_rd_i
);

    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(els_p - 1);
    localparam logic [c_cnt_w-1:0]  c_els_cnt   = c_cnt_w'(els_p);

    logic                w_op_fire;
    logic                w_rd_fire;
    logic                w_rd_hit;
    logic [width_p-1:0]  w_result;
    logic [width_p-1:0]  w_rd_ret;

    logic [c_addr_w-1:0] r_wptr;
    logic [c_cnt_w-1:0]  r_count;
    logic                r_sram_ce;
    logic                r_sram_we;
    logic [c_addr_w-1:0] r_sram_addr;
    logic [width_p-1:0]  r_sram_wd;
    logic                r_rd_p1;
    logic                r_rd_hit_p1;
    logic                r_rd_v;
    logic                r_rd_hit_p2;
    logic [width_p-1:0]  r_rd_hold;

    alu_result_logger_alu #(
        .width_p (width_p)
    ) u_alu (
        .sel_i (sel_i),
        .a_i   (a_i),
        .b_i   (b_i),
        .res_o (w_result)
    );

    // Reads win the single SRAM port, so a pending op stalls behind them.
    assign full_o     = (r_count == c_els_cnt);
    assign op_ready_o = ~reset & ~clear_i & ~rd_v_i & ((wrap_p != 0) | ~full_o);
    assign w_op_fire  = op_v_i & op_ready_o;
    assign w_rd_fire  = rd_v_i & ~reset;
    assign w_rd_hit   = w_rd_fire & (c_cnt_w'(rd_addr_i) < r_count);

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            r_wptr  <= '0;
            r_count <= '0;
        end else if (w_op_fire) begin
            r_wptr  <= (r_wptr == c_last_addr) ? '0 : r_wptr + 1'b1;
            r_count <= (r_count == c_els_cnt) ? r_count : r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sram_ce   <= 1'b0;
            r_sram_we   <= 1'b0;
            r_sram_addr <= '0;
            r_sram_wd   <= '0;
        end else begin
            r_sram_ce <= w_op_fire | w_rd_hit;
            r_sram_we <= w_op_fire;
            if (w_op_fire) begin
                r_sram_addr <= r_wptr;
                r_sram_wd   <= w_result;
            end else if (w_rd_hit) begin
                r_sram_addr <= rd_addr_i;
            end
        end
    end

    // Misses return zero on the same schedule as hits, without touching the SRAM.
    assign w_rd_ret = r_rd_hit_p2 ? sram_rd_i : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_p1     <= 1'b0;
            r_rd_hit_p1 <= 1'b0;
            r_rd_v      <= 1'b0;
            r_rd_hit_p2 <= 1'b0;
            r_rd_hold   <= '0;
        end else begin
            r_rd_p1     <= w_rd_fire;
            r_rd_hit_p1 <= w_rd_hit;
            r_rd_v      <= r_rd_p1;
            r_rd_hit_p2 <= r_rd_hit_p1;
            if (r_rd_v) begin
                r_rd_hold <= w_rd_ret;
            end
        end
    end

    assign rd_v_o        = r_rd_v;
    assign rd_data_o     = r_rd_v ? w_rd_ret : r_rd_hold;
    assign count_o       = r_count;
    assign sram_ce_o     = r_sram_ce;
    assign sram_we_o     = r_sram_we;
    assign sram_addr_o   = r_sram_addr;
    assign sram_wd_o     = r_sram_wd;
    assign sram_w_mask_o = '1;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_logger.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_logger
// Description : Directed self-checking bench over three logger configurations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_logger;

    logic clk = 1'b0;
    logic reset;

    logic       op_v    [3];
    logic [1:0] sel     [3];
    logic [7:0] a       [3];
    logic [7:0] b       [3];
    logic       rd_v    [3];
    logic [8:0] rd_addr [3];
    logic       clear   [3];

    logic       o_ready [3];
    logic       o_rdv   [3];
    logic       o_full  [3];
    logic       o_ce    [3];
    logic       o_we    [3];
    logic [9:0] o_cnt   [3];
    logic [9:0] o_addr  [3];
    logic [7:0] o_wd    [3];
    logic [7:0] o_rdd   [3];
    logic [7:0] o_mask  [3];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    // Instance 0: 512 deep, stop when full; 1: 4 deep, stop; 2: 4 deep, wrap.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int ELS  = (g == 0) ? 512 : 4;
        localparam int WRAP = (g == 2) ? 1 : 0;
        localparam int AW   = $clog2(ELS);
        localparam int CW   = $clog2(ELS + 1);

        logic [CW-1:0] cnt;
        logic [AW-1:0] saddr;
        logic [7:0]    swd;
        logic [7:0]    smask;
        logic [7:0]    srd;
        logic [7:0]    rdd;
        logic          rdy, rdv, full, ce, we;
        logic [7:0]    mem [ELS];

        alu_result_logger #(
            .width_p (8),
            .els_p   (ELS),
            .wrap_p  (WRAP)
        ) u_dut (
            .clk           (clk),
            .reset         (reset),
            .clear_i       (clear[g]),
            .op_v_i        (op_v[g]),
            .op_ready_o    (rdy),
            .sel_i         (sel[g]),
            .a_i           (a[g]),
            .b_i           (b[g]),
            .rd_v_i        (rd_v[g]),
            .rd_addr_i     (rd_addr[g][AW-1:0]),
            .rd_v_o        (rdv),
            .rd_data_o     (rdd),
            .count_o       (cnt),
            .full_o        (full),
            .sram_ce_o     (ce),
            .sram_we_o     (we),
            .sram_addr_o   (saddr),
            .sram_wd_o     (swd),
            .sram_w_mask_o (smask),
            .sram_rd_i     (srd)
        );

        always_ff @(posedge clk) begin
            if (ce) begin
                if (we) mem[saddr] <= swd;
                else    srd        <= mem[saddr];
            end
        end

        assign o_ready[g] = rdy;
        assign o_rdv[g]   = rdv;
        assign o_full[g]  = full;
        assign o_ce[g]    = ce;
        assign o_we[g]    = we;
        assign o_cnt[g]   = 10'(cnt);
        assign o_addr[g]  = 10'(saddr);
        assign o_wd[g]    = swd;
        assign o_rdd[g]   = rdd;
        assign o_mask[g]  = smask;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] t_sel [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0] t_a   [4] = '{8'd1, 8'd1, 8'd6, 8'd4};
        logic [7:0] t_b   [4] = '{8'd3, 8'd3, 8'd3, 8'd1};
        logic [7:0] t_exp [4] = '{8'h04, 8'hFE, 8'h02, 8'h05};

        for (int i = 0; i < 3; i++) begin
            op_v[i] = 0; sel[i] = 0; a[i] = 0; b[i] = 0;
            rd_v[i] = 0; rd_addr[i] = 0; clear[i] = 0;
        end
        reset = 1'b1;
        tick();
        tick();
        chk("rst_ce", o_ce[0], 0);
        chk("rst_cnt", o_cnt[0], 0);
        chk("rst_full", o_full[0], 0);
        chk("rst_rdv", o_rdv[0], 0);
        chk("rst_rdd", o_rdd[0], 0);
        chk("rst_ready", o_ready[0], 0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", o_ready[0], 1);
        chk("mask", o_mask[0], 8'hFF);

        // Back-to-back ADD/SUB/AND/OR
        for (int i = 0; i < 4; i++) begin
            op_v[0] = 1; sel[0] = t_sel[i]; a[0] = t_a[i]; b[0] = t_b[i];
            #1;
            chk("b2b_ready", o_ready[0], 1);
            tick();
            chk("b2b_ce", o_ce[0], 1);
            chk("b2b_we", o_we[0], 1);
            chk("b2b_addr", o_addr[0], i);
            chk("b2b_wd", o_wd[0], t_exp[i]);
        end
        op_v[0] = 0;
        chk("b2b_cnt", o_cnt[0], 4);
        tick();
        chk("idle_ce", o_ce[0], 0);

        // Readback hit at addr 1
        rd_v[0] = 1; rd_addr[0] = 1;
        #1;
        chk("rd_blocks_ready", o_ready[0], 0);
        tick();
        rd_v[0] = 0;
        chk("rd_ce", o_ce[0], 1);
        chk("rd_we", o_we[0], 0);
        chk("rd_addr", o_addr[0], 1);
        chk("rd_v_early", o_rdv[0], 0);
        tick();
        chk("rd_v", o_rdv[0], 1);
        chk("rd_data", o_rdd[0], 8'hFE);
        tick();
        chk("rd_v_pulse", o_rdv[0], 0);
        chk("rd_data_hold", o_rdd[0], 8'hFE);

        // Readback miss at addr 7
        rd_v[0] = 1; rd_addr[0] = 7;
        tick();
        rd_v[0] = 0;
        chk("miss_no_ce", o_ce[0], 0);
        tick();
        chk("miss_rdv", o_rdv[0], 1);
        chk("miss_data", o_rdd[0], 0);

        // Simultaneous read and op: read first, op stalls one cycle
        rd_v[0] = 1; rd_addr[0] = 0;
        op_v[0] = 1; sel[0] = 2'd0; a[0] = 8'd9; b[0] = 8'd9;
        #1;
        chk("arb_ready_low", o_ready[0], 0);
        tick();
        rd_v[0] = 0;
        #1;
        chk("arb_rd_ce", o_ce[0], 1);
        chk("arb_rd_we", o_we[0], 0);
        chk("arb_rd_addr", o_addr[0], 0);
        chk("arb_ready_high", o_ready[0], 1);
        tick();
        op_v[0] = 0;
        chk("arb_wr_we", o_we[0], 1);
        chk("arb_wr_addr", o_addr[0], 4);
        chk("arb_wr_wd", o_wd[0], 8'h12);
        chk("arb_rdv", o_rdv[0], 1);
        chk("arb_rdd", o_rdd[0], 8'h04);
        chk("arb_cnt", o_cnt[0], 5);

        // Depth 4, no wrap: fill, hold the fifth op, then clear
        for (int i = 0; i < 4; i++) begin
            op_v[1] = 1; sel[1] = 2'd0; a[1] = 8'(i + 1); b[1] = 8'd0;
            tick();
        end
        chk("full_last_addr", o_addr[1], 3);
        a[1] = 8'h55;
        #1;
        chk("full_flag", o_full[1], 1);
        chk("full_ready", o_ready[1], 0);
        chk("full_cnt", o_cnt[1], 4);
        tick();
        chk("full_no_wr0", o_ce[1], 0);
        tick();
        chk("full_no_wr1", o_ce[1], 0);
        chk("full_cnt_hold", o_cnt[1], 4);
        clear[1] = 1;
        #1;
        chk("clear_ready", o_ready[1], 0);
        tick();
        clear[1] = 0; op_v[1] = 0;
        #1;
        chk("clear_cnt", o_cnt[1], 0);
        chk("clear_full", o_full[1], 0);
        chk("clear_ready_back", o_ready[1], 1);

        // Depth 4, wrap: six ADD(i,0)
        for (int i = 0; i < 6; i++) begin
            op_v[2] = 1; sel[2] = 2'd0; a[2] = 8'(i); b[2] = 8'd0;
            #1;
            chk("wrap_ready", o_ready[2], 1);
            tick();
            chk("wrap_addr", o_addr[2], i % 4);
            chk("wrap_wd", o_wd[2], i);
        end
        op_v[2] = 0;
        chk("wrap_cnt", o_cnt[2], 4);
        chk("wrap_full", o_full[2], 1);
        rd_v[2] = 1; rd_addr[2] = 0;
        tick();
        rd_v[2] = 0;
        tick();
        chk("wrap_rdv", o_rdv[2], 1);
        chk("wrap_rdd", o_rdd[2], 4);

        // Reset the cycle after a read request drops the read
        rd_v[2] = 1; rd_addr[2] = 2;
        tick();
        rd_v[2] = 0; reset = 1'b1;
        tick();
        chk("rrst_ce", o_ce[2], 0);
        chk("rrst_we", o_we[2], 0);
        chk("rrst_addr", o_addr[2], 0);
        chk("rrst_wd", o_wd[2], 0);
        chk("rrst_cnt", o_cnt[2], 0);
        chk("rrst_rdv0", o_rdv[2], 0);
        reset = 1'b0;
        tick();
        chk("rrst_rdv1", o_rdv[2], 0);
        tick();
        chk("rrst_rdv2", o_rdv[2], 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
